// File: rtl/uart_pkg.sv
// Shared UART receive definitions: sequencer states, word-length codes and
// the default oversampling ratio.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Serial line, line-control and received-character signals of the UART
// receive sequencer.
interface uart_rx_fsm_if;

    logic       baud_tick;
    logic       rx_in;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rsr_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       break_det;
    logic       rx_busy;

    modport master (
        output baud_tick, rx_in, wls, pen, eps, sp,
        input  rsr_data, data_valid, parity_error, framing_error, break_det, rx_busy
    );

    modport slave (
        input  baud_tick, rx_in, wls, pen, eps, sp,
        output rsr_data, data_valid, parity_error, framing_error, break_det, rx_busy
    );

endinterface

// File: rtl/uart_rx_fsm_parity_checker.sv
// Combinational parity check of a received character against its parity bit,
// covering odd, even and stick parity.
module parity_checker (
    input  logic [7:0] data,
    input  logic       par_bit,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic       parity_error_c
);

    // Stick parity forces the bit to ~eps; otherwise the total count of ones
    // (data + parity) must be even when eps=1 and odd when eps=0.
    always_comb begin
        parity_error_c = 1'b0;
        if (pen) begin
            if (sp) begin
                parity_error_c = (par_bit == eps);
            end else begin
                parity_error_c = (^data) ^ par_bit ^ ~eps;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start detection, mid-bit sampling of data, parity
// and stop bits on a 16x baud enable, and per-frame result publication.
module uart_rx_fsm #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fsm_if.slave  bus
);

    import uart_pkg::*;

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    rx_state_t     state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rx_par;
    logic [2:0]    last_bit_c;
    logic          par_err_c;
    logic          brk_c;

    assign last_bit_c = {1'b0, bus.wls} + 3'd4;
    assign brk_c      = (shift == 8'h00) & (~bus.pen | ~rx_par) & ~bus.rx_in;

    parity_checker u_parity (
        .data           (shift),
        .par_bit        (rx_par),
        .pen            (bus.pen),
        .eps            (bus.eps),
        .sp             (bus.sp),
        .parity_error_c (par_err_c)
    );

    // Sequencer; everything except the data_valid pulse advances only on baud_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            rx_par            <= 1'b0;
            bus.rsr_data      <= '0;
            bus.data_valid    <= 1'b0;
            bus.parity_error  <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.break_det     <= 1'b0;
            bus.rx_busy       <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            if (bus.baud_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!bus.rx_in) begin
                            state       <= START;
                            tick_cnt    <= '0;
                            shift       <= '0;
                            rx_par      <= 1'b0;
                            bus.rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= '0;
                            if (bus.rx_in) begin
                                state       <= IDLE;
                                bus.rx_busy <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt       <= '0;
                            shift[bit_cnt] <= bus.rx_in;
                            if (bit_cnt == last_bit_c) begin
                                state <= bus.pen ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            rx_par   <= bus.rx_in;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    STOP: begin
                        // Leave at mid-stop so a start edge in its second half is caught.
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt          <= '0;
                            bus.rsr_data      <= shift;
                            bus.parity_error  <= par_err_c;
                            bus.framing_error <= ~bus.rx_in;
                            bus.break_det     <= brk_c;
                            bus.data_valid    <= 1'b1;
                            if (brk_c) begin
                                state <= BRK_WAIT;
                            end else begin
                                state       <= IDLE;
                                bus.rx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    BRK_WAIT: begin
                        if (bus.rx_in) begin
                            state       <= IDLE;
                            bus.rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed and random frames checked against a
// frame-level model of the receiver.
module tb_uart_rx_fsm;

    logic clk;
    logic rst;
    uart_rx_fsm_if bus();

    uart_rx_fsm #(.OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int tick_num      = 0;
    bit last_pos_tick = 1'b0;
    int dv_cnt        = 0;
    int dv_tick       = 0;
    bit dv_on_tick    = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk baud enable every fourth clock, changed on the falling edge.
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.baud_tick = 1'b1;
            @(negedge clk);
            bus.baud_tick = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(posedge clk) begin
        last_pos_tick <= bus.baud_tick;
        if (bus.baud_tick) tick_num <= tick_num + 1;
    end

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_cnt     <= dv_cnt + 1;
            dv_tick    <= tick_num;
            dv_on_tick <= last_pos_tick;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.baud_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input bit b);
        @(negedge clk);
        bus.rx_in = b;
        tick_wait(16);
    endtask

    // Sends one frame and checks the published result against the frame rules.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] w,
                             input bit p, input bit e, input bit s,
                             input bit parbit, input bit stopbit);
        int         n;
        int         dv0;
        int         st;
        logic [7:0] dm;
        bit         exp_pe, exp_fe, exp_bk;
        n  = 5 + int'(w);
        dm = d & 8'((1 << n) - 1);
        if (!p)     exp_pe = 1'b0;
        else if (s) exp_pe = (parbit != !e);
        else        exp_pe = ((($countones(dm) + int'(parbit)) % 2) != (e ? 0 : 1));
        exp_fe = !stopbit;
        exp_bk = (dm == 8'h00) && (!p || !parbit) && !stopbit;
        bus.wls = w; bus.pen = p; bus.eps = e; bus.sp = s;
        dv0 = dv_cnt;
        @(negedge clk);
        st = tick_num + 1;
        bus.rx_in = 1'b0;
        tick_wait(16);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (p) drive_bit(parbit);
        drive_bit(stopbit);
        @(negedge clk);
        bus.rx_in = 1'b1;
        tick_wait(24);
        @(negedge clk);
        check({tag, ".dv_count"}, 32'(dv_cnt - dv0), 32'd1);
        check({tag, ".data"}, 32'(bus.rsr_data), 32'(dm));
        check({tag, ".parity_error"}, 32'(bus.parity_error), 32'(exp_pe));
        check({tag, ".framing_error"}, 32'(bus.framing_error), 32'(exp_fe));
        check({tag, ".break_det"}, 32'(bus.break_det), 32'(exp_bk));
        check({tag, ".latency"}, 32'(dv_tick - st), 32'(8 + 16 * (1 + n + int'(p))));
        check({tag, ".dv_on_tick"}, 32'(dv_on_tick), 32'd1);
        check({tag, ".busy_after"}, 32'(bus.rx_busy), 32'd0);
    endtask

    initial begin
        int         dv0;
        int         st;
        logic [7:0] d;
        logic [1:0] w;
        bit         p, e, s, pb, sb;

        rst = 1'b1;
        bus.rx_in = 1'b1;
        bus.wls = 2'b11; bus.pen = 1'b0; bus.eps = 1'b0; bus.sp = 1'b0;
        repeat (5) @(negedge clk);
        check("reset.data", 32'(bus.rsr_data), 32'd0);
        check("reset.flags", 32'({bus.data_valid, bus.parity_error, bus.framing_error,
                                  bus.break_det, bus.rx_busy}), 32'd0);
        rst = 1'b0;
        tick_wait(4);

        run_frame("8n1_a5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("7e1_ok", 8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame("7e1_bad", 8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        run_frame("stick_ok", 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_frame("stick_bad", 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame("5bit_mask", 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("framing", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short low glitch: false start, no frame, flags untouched.
        dv0 = dv_cnt;
        @(negedge clk);
        bus.rx_in = 1'b0;
        tick_wait(4);
        @(negedge clk);
        check("glitch.busy_during", 32'(bus.rx_busy), 32'd1);
        bus.rx_in = 1'b1;
        tick_wait(24);
        @(negedge clk);
        check("glitch.busy_after", 32'(bus.rx_busy), 32'd0);
        check("glitch.no_dv", 32'(dv_cnt - dv0), 32'd0);
        check("glitch.fe_held", 32'(bus.framing_error), 32'd1);
        check("glitch.data_held", 32'(bus.rsr_data), 32'h3C);

        // Reset in the middle of DATA aborts the frame and clears outputs.
        dv0 = dv_cnt;
        bus.rx_in = 1'b0;
        tick_wait(16);
        drive_bit(1'b1);
        drive_bit(1'b0);
        tick_wait(5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.data", 32'(bus.rsr_data), 32'd0);
        check("rst_mid.flags", 32'({bus.data_valid, bus.parity_error, bus.framing_error,
                                    bus.break_det, bus.rx_busy}), 32'd0);
        bus.rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick_wait(40);
        @(negedge clk);
        check("rst_mid.no_dv", 32'(dv_cnt - dv0), 32'd0);
        run_frame("after_rst", 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Line held low for three 8N1 frame times.
        bus.wls = 2'b11; bus.pen = 1'b0; bus.eps = 1'b0; bus.sp = 1'b0;
        dv0 = dv_cnt;
        @(negedge clk);
        st = tick_num + 1;
        bus.rx_in = 1'b0;
        tick_wait(480);
        @(negedge clk);
        check("break.dv_once", 32'(dv_cnt - dv0), 32'd1);
        check("break.break_det", 32'(bus.break_det), 32'd1);
        check("break.framing_error", 32'(bus.framing_error), 32'd1);
        check("break.data", 32'(bus.rsr_data), 32'd0);
        check("break.latency", 32'(dv_tick - st), 32'd152);
        check("break.busy_hold", 32'(bus.rx_busy), 32'd1);
        bus.rx_in = 1'b1;
        tick_wait(2);
        @(negedge clk);
        check("break.busy_release", 32'(bus.rx_busy), 32'd0);
        tick_wait(24);
        @(negedge clk);
        check("break.no_more_dv", 32'(dv_cnt - dv0), 32'd1);
        check("break.flag_held", 32'(bus.break_det), 32'd1);

        // Random frames of all formats, mostly well-formed.
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            w = 2'($urandom_range(0, 3));
            p = 1'($urandom); e = 1'($urandom); s = 1'($urandom);
            if (s) pb = !e;
            else   pb = e ? (^(d & 8'((1 << (5 + int'(w))) - 1)))
                          : ~(^(d & 8'((1 << (5 + int'(w))) - 1)));
            if ($urandom_range(0, 9) < 3) pb = !pb;
            sb = ($urandom_range(0, 9) < 8);
            if (k == 3) begin d = 8'h00; p = 1'b0; sb = 1'b0; end
            run_frame($sformatf("rand%0d", k), d, w, p, e, s, pb, sb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
